// File: rtl/api_wb_master.sv
// Wishbone initiator for the API register block. Runs one job per start:
// flush, program SCK/timeout, push tx words under TXFIFO credits, drain RXFIFO.
module api_wb_master #(
  parameter int          TXFIFO_DEPTH = 512,
  parameter logic [15:0] POLL_MAX     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  tx_len,
  input  logic [8:0]  rx_len,
  input  logic [7:0]  cfg_sck,
  input  logic [5:0]  cfg_ch_num,
  input  logic [7:0]  cfg_word_num,
  input  logic [27:0] cfg_timeout,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        API_CYC_O,
  output logic        API_STB_O,
  output logic        API_WE_O,
  output logic [5:0]  API_ADR_O,
  output logic [31:0] API_DAT_O,
  output logic [3:0]  API_SEL_O,
  output logic [2:0]  API_CTI_O,
  output logic [1:0]  API_BTE_O,
  output logic        API_LOCK_O,
  input  logic        API_ACK_I,
  input  logic [31:0] API_DAT_I,
  input  logic        API_ERR_I,
  input  logic        API_RTY_I
);
  localparam logic [5:0] A_TX = 6'h00, A_RX = 6'h04, A_ST = 6'h08, A_TO = 6'h0C, A_SCK = 6'h10;

  typedef enum logic [3:0] {
    S_IDLE, S_FLUSH, S_FLUSH_W, S_CFG_SCK, S_CFG_TO,
    S_TX_POLL, S_TX_PUSH, S_RX_POLL, S_RX_POP, S_FIN
  } state_t;

  state_t      state;
  logic        stb, we, gap;
  logic [5:0]  adr;
  logic [31:0] dat_o;
  logic [2:0]  wcnt;
  logic [15:0] poll_cnt;
  logic [9:0]  tx_rem;
  logic [10:0] credits;
  logic [8:0]  rx_rem, avail;
  logic [7:0]  sck_q, word_q;
  logic [5:0]  ch_q;
  logic [27:0] to_q;

  // retry is not part of this protocol subset
  logic unused_rty;
  assign unused_rty = API_RTY_I;

  // STATE register decode of the current read data
  logic        st_txfull, st_rxempty;
  logic [10:0] st_txcnt, free, tx_take, depth_w;
  logic [8:0]  st_rxcnt, rx_take;
  assign depth_w    = 11'(TXFIFO_DEPTH);
  assign st_txfull  = API_DAT_I[0];
  assign st_txcnt   = {1'b0, API_DAT_I[11:2]};
  assign st_rxempty = API_DAT_I[16];
  assign st_rxcnt   = API_DAT_I[28:20];
  assign free       = (st_txcnt >= depth_w) ? 11'd0 : depth_w - st_txcnt;
  assign tx_take    = (free < {1'b0, tx_rem}) ? free : {1'b0, tx_rem};
  assign rx_take    = (st_rxcnt < rx_rem) ? st_rxcnt : rx_rem;

  // a tx word is taken on the very edge that launches its write
  assign tx_ready = (state == S_TX_PUSH) && !stb && !gap && tx_valid;

  assign API_CYC_O  = stb;
  assign API_STB_O  = stb;
  assign API_WE_O   = we;
  assign API_ADR_O  = adr;
  assign API_DAT_O  = dat_o;
  assign API_SEL_O  = 4'hF;
  assign API_CTI_O  = 3'b000;
  assign API_BTE_O  = 2'b00;
  assign API_LOCK_O = 1'b0;

  // job FSM and bus cycle engine; gap forces one idle cycle after every access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE; stb <= 1'b0; we <= 1'b0; gap <= 1'b0; adr <= '0; dat_o <= '0;
      wcnt <= '0; poll_cnt <= '0; tx_rem <= '0; credits <= '0; rx_rem <= '0; avail <= '0;
      sck_q <= '0; word_q <= '0; ch_q <= '0; to_q <= '0;
      rx_valid <= 1'b0; rx_data <= '0; busy <= 1'b0; done <= 1'b0; err <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      if (gap) gap <= 1'b0;
      if (stb && API_ERR_I) begin
        stb <= 1'b0; we <= 1'b0; gap <= 1'b1; err <= 1'b1; state <= S_FIN;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            tx_rem <= tx_len; rx_rem <= rx_len; sck_q <= cfg_sck; ch_q <= cfg_ch_num;
            word_q <= cfg_word_num; to_q <= cfg_timeout; poll_cnt <= '0;
            err <= 1'b0; busy <= 1'b1; state <= S_FLUSH;
          end
          S_FLUSH:
            if (!stb && !gap) begin stb <= 1'b1; we <= 1'b1; adr <= A_ST; dat_o <= 32'h2; end
            else if (stb && API_ACK_I) begin
              stb <= 1'b0; we <= 1'b0; gap <= 1'b1; wcnt <= '0; state <= S_FLUSH_W;
            end
          // give the slave's flush pulse time to settle
          S_FLUSH_W: begin
            wcnt <= wcnt + 3'd1;
            if (wcnt == 3'd3) state <= S_CFG_SCK;
          end
          S_CFG_SCK:
            if (!stb && !gap) begin
              stb <= 1'b1; we <= 1'b1; adr <= A_SCK; dat_o <= {word_q, 2'b0, ch_q, 8'h0, sck_q};
            end else if (stb && API_ACK_I) begin
              stb <= 1'b0; we <= 1'b0; gap <= 1'b1; state <= S_CFG_TO;
            end
          S_CFG_TO:
            if (!stb && !gap) begin
              stb <= 1'b1; we <= 1'b1; adr <= A_TO; dat_o <= {4'h0, to_q};
            end else if (stb && API_ACK_I) begin
              stb <= 1'b0; we <= 1'b0; gap <= 1'b1;
              state <= (tx_rem != 0) ? S_TX_POLL : (rx_rem != 0) ? S_RX_POLL : S_FIN;
            end
          S_TX_POLL:
            if (!stb && !gap) begin stb <= 1'b1; we <= 1'b0; adr <= A_ST; end
            else if (stb && API_ACK_I) begin
              stb <= 1'b0; gap <= 1'b1;
              if (st_txfull || free == 0) begin
                if (poll_cnt == POLL_MAX - 16'd1) begin err <= 1'b1; state <= S_FIN; end
                else poll_cnt <= poll_cnt + 16'd1;
              end else begin
                credits <= tx_take; poll_cnt <= '0; state <= S_TX_PUSH;
              end
            end
          S_TX_PUSH:
            if (!stb && !gap) begin
              if (tx_valid) begin stb <= 1'b1; we <= 1'b1; adr <= A_TX; dat_o <= tx_data; end
            end else if (stb && API_ACK_I) begin
              stb <= 1'b0; we <= 1'b0; gap <= 1'b1;
              credits <= credits - 11'd1; tx_rem <= tx_rem - 10'd1;
              if (tx_rem == 10'd1) state <= (rx_rem != 0) ? S_RX_POLL : S_FIN;
              else if (credits == 11'd1) state <= S_TX_POLL;
            end
          S_RX_POLL:
            if (!stb && !gap) begin stb <= 1'b1; we <= 1'b0; adr <= A_ST; end
            else if (stb && API_ACK_I) begin
              stb <= 1'b0; gap <= 1'b1;
              if (st_rxempty || st_rxcnt == 0) begin
                if (poll_cnt == POLL_MAX - 16'd1) begin err <= 1'b1; state <= S_FIN; end
                else poll_cnt <= poll_cnt + 16'd1;
              end else begin
                avail <= rx_take; poll_cnt <= '0; state <= S_RX_POP;
              end
            end
          S_RX_POP:
            if (!stb && !gap) begin stb <= 1'b1; we <= 1'b0; adr <= A_RX; end
            else if (stb && API_ACK_I) begin
              stb <= 1'b0; gap <= 1'b1; rx_data <= API_DAT_I; rx_valid <= 1'b1;
              avail <= avail - 9'd1; rx_rem <= rx_rem - 9'd1;
              if (rx_rem == 9'd1) state <= S_FIN;
              else if (avail == 9'd1) state <= S_RX_POLL;
            end
          S_FIN: begin done <= 1'b1; busy <= 1'b0; state <= S_IDLE; end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
